msg_uplink_serializer: RTL and testbench

//  Drains the 128-bit uplink message FIFO filled by the per-channel message transmit stage.

---
 rtl/msg_uplink_pkg.sv | 26 ++
 rtl/msg_word_splitter.sv | 49 ++++
 rtl/msg_uplink_serializer.sv | 117 +++++++++++
 tb/tb_msg_uplink_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_uplink_pkg.sv
// Framing constants, header field positions and FSM encoding shared by the uplink serializer.
// Also used by the transmit-side framing so both ends agree on the header layout.
package msg_uplink_pkg;

  localparam logic [31:0] HEADER_DEFAULT    = 32'hFDF7_EB90;
  localparam logic [15:0] MAX_WORDS_DEFAULT = 16'd512;

  localparam int HDR_SYNC_MSB = 127;
  localparam int HDR_SYNC_LSB = 96;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_SEND,
    S_CSUM,
    S_RESYNC
  } state_t;

  function automatic logic len_ok(input logic [15:0] len, input logic [15:0] max_words);
    return (len != 16'd0) && (len <= max_words);
  endfunction

endpackage

// File: rtl/msg_word_splitter.sv
// Holds one 128-bit word and presents it as four 32-bit beats, MSB beat first; zero-cycle beat latency.
// Beats only advance on beat_vld && beat_rdy, so data is held steady through downstream stalls.
module msg_word_splitter (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic         load,
  input  logic [127:0] word_dat,
  input  logic         en,
  input  logic         beat_rdy,
  output logic [127:0] hold_dat,
  output logic [31:0]  beat_dat,
  output logic         beat_vld,
  output logic         beat_last,
  output logic         beat_fire
);

  logic [1:0] beat_cnt;
  logic       word_vld;

  assign beat_vld  = en && word_vld;
  assign beat_fire = beat_vld && beat_rdy;
  assign beat_last = (beat_cnt == 2'd3);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_dat <= '0;
      beat_cnt <= 2'd0;
      word_vld <= 1'b0;
    end else if (load) begin
      hold_dat <= word_dat;
      beat_cnt <= 2'd0;
      word_vld <= 1'b1;
    end else if (beat_fire) begin
      beat_cnt <= beat_cnt + 2'd1;
      if (beat_last) word_vld <= 1'b0;
    end
  end

  always_comb begin
    beat_dat = hold_dat[31:0];
    case (beat_cnt)
      2'd0:    beat_dat = hold_dat[127:96];
      2'd1:    beat_dat = hold_dat[95:64];
      2'd2:    beat_dat = hold_dat[63:32];
      default: beat_dat = hold_dat[31:0];
    endcase
  end

endmodule

// File: rtl/msg_uplink_serializer.sv
// Drains the 128-bit uplink FIFO into a 32-bit stream, checking headers and closing each frame with a checksum beat.
// FIFO read to first beat is 3 cycles; stream backpressure stalls the current beat and suspends further FIFO reads.
module msg_uplink_serializer
  import msg_uplink_pkg::*;
#(
  parameter logic [31:0] HEADER    = HEADER_DEFAULT,
  parameter logic [15:0] MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  output logic         fifo_rd_en_o,
  input  logic [127:0] fifo_dout_i,
  input  logic         fifo_empty_i,
  output logic [31:0]  m_tdata_o,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic         m_tlast_o,
  output logic [15:0]  frame_cnt_o,
  output logic [15:0]  drop_cnt_o,
  output logic         busy_o
);

  state_t        state;
  logic          hdr_exp;
  logic [15:0]   words_left;
  logic [31:0]   csum;
  logic [127:0]  hold_dat;
  logic [31:0]   beat_dat;
  logic          beat_vld;
  logic          beat_last;
  logic          beat_fire;
  logic          load;
  logic          sync_ok;
  logic [15:0]   hdr_len;

  // FIFO data is valid the cycle after the read strobe drops, so capture only then.
  assign load    = (state == S_FETCH) && !fifo_rd_en_o;
  assign sync_ok = (hold_dat[HDR_SYNC_MSB:HDR_SYNC_LSB] == HEADER);
  assign hdr_len = hold_dat[HDR_LEN_MSB:HDR_LEN_LSB];

  msg_word_splitter u_splitter (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .load      (load),
    .word_dat  (fifo_dout_i),
    .en        (state == S_SEND),
    .beat_rdy  (m_tready_i),
    .hold_dat  (hold_dat),
    .beat_dat  (beat_dat),
    .beat_vld  (beat_vld),
    .beat_last (beat_last),
    .beat_fire (beat_fire)
  );

  assign m_tvalid_o = beat_vld || (state == S_CSUM);
  assign m_tdata_o  = (state == S_CSUM) ? csum : beat_dat;
  assign m_tlast_o  = (state == S_CSUM);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      hdr_exp      <= 1'b0;
      words_left   <= 16'd0;
      csum         <= 32'd0;
      fifo_rd_en_o <= 1'b0;
      frame_cnt_o  <= 16'd0;
      drop_cnt_o   <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_RESYNC: begin
          if (!fifo_empty_i) begin
            fifo_rd_en_o <= 1'b1;
            hdr_exp      <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fifo_rd_en_o) fifo_rd_en_o <= 1'b0;
          else              state <= hdr_exp ? S_CHECK : S_SEND;
        end
        S_CHECK: begin
          if (sync_ok && len_ok(hdr_len, MAX_WORDS)) begin
            words_left <= hdr_len - 16'd1;
            csum       <= 32'd0;
            state      <= S_SEND;
          end else begin
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            state <= S_RESYNC;
          end
        end
        S_SEND: begin
          if (beat_fire) csum <= csum + beat_dat;
          // Word exhausted (or still waiting on an empty FIFO): fetch the next one or close the frame.
          if ((beat_fire && beat_last) || !beat_vld) begin
            if (words_left == 16'd0) begin
              state <= S_CSUM;
            end else if (!fifo_empty_i) begin
              fifo_rd_en_o <= 1'b1;
              hdr_exp      <= 1'b0;
              words_left   <= words_left - 16'd1;
              state        <= S_FETCH;
            end
          end
        end
        S_CSUM: begin
          if (m_tready_i) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_uplink_serializer.sv
// Directed bench: models a standard-mode FIFO and checks stream beats, checksums, counters and reset behaviour.
module tb_msg_uplink_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_rd_en;
  logic [127:0] fifo_dout = '0;
  logic         fifo_empty;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [15:0]  frame_cnt;
  logic [15:0]  drop_cnt;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] mem [64];
  logic [5:0]   wr_ptr = 6'd0;
  logic [5:0]   rd_ptr = 6'd0;

  logic [31:0]  exp_q [$];
  logic         exp_close;
  logic         stalled;
  logic [31:0]  held_dat;

  localparam logic [127:0] F1_W0 = {32'hFDF7EB90, 80'h0, 16'd2};
  localparam logic [127:0] F1_W1 = {32'h1, 32'h2, 32'h3, 32'h4};
  localparam logic [127:0] L1_W0 = {32'hFDF7EB90, 80'h0, 16'd1};

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  msg_uplink_serializer dut (
    .sys_clk_i    (clk),
    .rst_n_i      (rst_n),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_dout_i  (fifo_dout),
    .fifo_empty_i (fifo_empty),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .m_tlast_o    (m_tlast),
    .frame_cnt_o  (frame_cnt),
    .drop_cnt_o   (drop_cnt),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic exp_word(input logic [127:0] w);
    exp_q.push_back(w[127:96]);
    exp_q.push_back(w[95:64]);
    exp_q.push_back(w[63:32]);
    exp_q.push_back(w[31:0]);
  endtask

  task automatic sample();
    logic [31:0] e;
    if (stalled) begin
      chk("stall_vld", 32'(m_tvalid), 32'd1);
      chk("stall_dat", m_tdata, held_dat);
    end
    stalled  = m_tvalid && !m_tready;
    held_dat = m_tdata;
    if (fifo_rd_en) chk("rd_on_empty", 32'(fifo_empty), 32'd0);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(m_tvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", m_tdata, e);
        chk("tlast", 32'(m_tlast), 32'(exp_close && (exp_q.size() == 0)));
      end
    end
  endtask

  // mode 0: tready held high; mode 1: tready toggles every cycle
  task automatic run(input int budget, input int mode);
    int n = 0;
    stalled = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      n++;
      m_tready = (mode == 1) ? ~m_tready : 1'b1;
    end
    chk("timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_tready = 1'b1;
  endtask

  task automatic idle(input int cycles);
    stalled = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b1;
    exp_close = 1'b1;
    stalled  = 1'b0;
    held_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // LEN=2 frame at full rate
    push(F1_W0);
    push(F1_W1);
    exp_word(F1_W0);
    exp_word(F1_W1);
    exp_q.push_back(32'hFDF7EB9C);
    exp_close = 1'b1;
    run(200, 0);
    idle(2);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_drop_cnt", 32'(drop_cnt), 32'd0);

    // same frame with tready toggling
    push(F1_W0);
    push(F1_W1);
    exp_word(F1_W0);
    exp_word(F1_W1);
    exp_q.push_back(32'hFDF7EB9C);
    run(400, 1);
    idle(2);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // mid-frame FIFO gap of 20 cycles
    push(F1_W0);
    exp_word(F1_W0);
    exp_close = 1'b0;
    run(200, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("gap_tvalid", 32'(m_tvalid), 32'd0);
    end
    chk("gap_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    push(F1_W1);
    exp_word(F1_W1);
    exp_q.push_back(32'hFDF7EB9C);
    exp_close = 1'b1;
    run(200, 0);
    idle(2);
    chk("gap_frame_cnt", 32'(frame_cnt), 32'd3);

    // three garbage words ahead of a LEN=1 frame
    push({32'hDEADBEEF, 32'h1, 32'h2, 32'h3});
    push(128'h0);
    push({32'hFDF7EB91, 80'h0, 16'd1});
    push(L1_W0);
    exp_word(L1_W0);
    exp_q.push_back(32'hFDF7EB91);
    run(300, 0);
    idle(2);
    chk("resync_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("resync_frame_cnt", 32'(frame_cnt), 32'd4);

    // LEN=0 and LEN=MAX_WORDS+1 headers are both rejected
    push({32'hFDF7EB90, 80'h0, 16'd0});
    push({32'hFDF7EB90, 80'h0, 16'd513});
    idle(30);
    chk("badlen_drop_cnt", 32'(drop_cnt), 32'd5);
    chk("badlen_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("badlen_busy", 32'(busy), 32'd1);
    push(L1_W0);
    exp_word(L1_W0);
    exp_q.push_back(32'hFDF7EB91);
    run(200, 0);
    idle(2);
    chk("badlen_after_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("badlen_after_busy", 32'(busy), 32'd0);

    // reset in the middle of a LEN=3 frame
    push({32'hFDF7EB90, 80'h0, 16'd3});
    push({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    push({32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888});
    exp_q.push_back(32'hFDF7EB90);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h11111111);
    exp_close = 1'b0;
    run(200, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_tlast", 32'(m_tlast), 32'd0);
    chk("midrst_tdata", m_tdata, 32'd0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_close = 1'b1;
    push(L1_W0);
    exp_word(L1_W0);
    exp_q.push_back(32'hFDF7EB91);
    run(300, 0);
    idle(2);
    chk("postrst_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("postrst_drop_cnt", 32'(drop_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
